vga_frame_analyzer: RTL and testbench
=====================================

# vga_frame_analyzer

Receive-side counterpart of the VGA output path: samples the 25 MHz pixel stream (Hsync, Vsync, blankVGA, R/G/B) and recovers row/column position from the sync and blank signals. Checks the stream against 640x480@60 timing and finds the bounding box of target-coloured pixels in each frame. Reports the box centre on CircleRow/CircleCol. Used in the bench and on-board loopback to close the loop from button movement to displayed circle position.

## Interface
- HIT_LEVEL, 128: channel threshold. A pixel is a hit when R >= HIT_LEVEL, G < HIT_LEVEL and B < HIT_LEVEL.
- LOCK_FRAMES, 2: number of consecutive conforming frames required to enter LOCKED.
- clk25  input  1  pixel clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Hsync  input  1  horizontal sync, active low.
- Vsync  input  1  vertical sync, active low.
- blankVGA  input  1  high = active video, low = blanking.
- R, G, B  input  8 each  pixel colour.
- locked  output  1  stream timing conforms.
- found  output  1  last completed frame contained at least one hit.
- frameDone  output  1  one-cycle pulse when frame results update.
- CircleRow  output  9  centre row of the last found box.
- CircleCol  output  10  centre column of the last found box.

## Operation
- All inputs are registered once (stage S1). Edge detection compares S1 against a second register (S2).
- Column counter: cleared on the rising edge of blankVGA; increments on each active pixel.
- Row counter:
  - cleared on the falling edge of Vsync;
  - increments on the falling edge of Hsync when the preceding line contained at least one active pixel.
- Measurements, latched at the falling edge of Vsync:
  - activeWidth = active pixel count of the last line;
  - activeLines = row count;
  - lineTotal = Hsync falling edges since the previous Vsync falling edge.
- A frame conforms when activeWidth = 640, activeLines = 480 and lineTotal = 525.
- State machine:
  - SEARCH: go to LOCKING after the first Vsync falling edge.
  - LOCKING: count conforming frames. Any non-conforming frame returns to LOCKING with the count cleared. When the count reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: one non-conforming frame returns to SEARCH.
- Hit tracking:
  - On each active pixel that is a hit, update minRow, maxRow, minCol and maxCol.
  - The bounding-box registers reset at every Vsync falling edge, after results are computed.
- Frame end, evaluated only in LOCKED with a conforming frame:
  - If any hits: CircleRow = (minRow+maxRow)>>1 and CircleCol = (minCol+maxCol)>>1, both computed 1 bit wider, then truncated. found = 1.
  - If no hits: found = 0; CircleRow/CircleCol hold their previous values.
  - Outside LOCKED: found = 0, coordinates hold, frameDone still pulses.
- A hit counted while the column counter is >= 640 or the row counter is >= 480 is ignored; counters saturate at 1023/511.

## Timing
- Reset values: locked = 0, found = 0, frameDone = 0, CircleRow = 0, CircleCol = 0, state = SEARCH, all counters 0.
- Latency:
  - Vsync low first presented at clk edge N.
  - Edge detected at N+1.
  - Results and frameDone = 1 at N+2.
  - frameDone = 0 at N+3.
- locked changes on the same cycle as frameDone.
- Reset asserted mid-frame discards partial measurements. The first frame after reset never conforms; it only enters LOCKING.
- Hsync and Vsync falling on the same cycle: the row increment is applied before the Vsync clear, so the last line is counted in lineTotal.

## Configuration
- VGA_RX_PIXCOUNT_EN defined:
  - adds output hitCount [18:0], the number of hit pixels in the last completed frame;
  - it updates with frameDone, resets to 0, and saturates at 307200.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package vga_rx_pkg holds:
  - H_ACTIVE = 640, V_ACTIVE = 480, V_TOTAL = 525;
  - the state enum (SEARCH, LOCKING, LOCKED);
  - row/column width typedefs (9 and 10 bits).
- Sub-module vga_pos_counter: input registers, edge detection, row/column counters and per-frame measurements. The top level holds the lock FSM and the bounding box.

## Test plan
- Reset, then three conforming 640x480 frames, all pixels black -> locked = 1 at the frameDone ending frame 3; found = 0; CircleRow/CircleCol = 0.
- Locked stream with a 20x20 red square (R = 255, G = 0, B = 0) at rows 100..119, cols 200..219 -> CircleRow = 109, CircleCol = 209, found = 1.
- Single hit pixel at row 479, col 639 -> CircleRow = 479, CircleCol = 639.
- Locked stream, then one frame with 524 lines -> locked = 0 at that frameDone; found = 0; coordinates hold; two further good frames -> locked = 1.
- reset pulsed at row 240 -> all outputs 0 next cycle; relock requires three Vsync edges.
- VGA_RX_PIXCOUNT_EN defined, the 20x20 square from the second scenario -> hitCount = 400.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared constants and types for the VGA receive-side frame analyzer.
package vga_rx_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    localparam int unsigned ROW_W = 9;
    localparam int unsigned COL_W = 10;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        LOCKED
    } rx_state_e;

endpackage

// File: rtl/vga_frame_analyzer_if.sv
// Pixel stream in, frame results out. hitCount exists only with VGA_RX_PIXCOUNT_EN.
interface vga_frame_analyzer_if;

    logic                  Hsync;
    logic                  Vsync;
    logic                  blankVGA;
    logic [7:0]            R;
    logic [7:0]            G;
    logic [7:0]            B;
    logic                  locked;
    logic                  found;
    logic                  frameDone;
    vga_rx_pkg::row_t      CircleRow;
    vga_rx_pkg::col_t      CircleCol;
`ifdef VGA_RX_PIXCOUNT_EN
    logic [18:0]           hitCount;
`endif

    // Video source side
    modport master (
        output Hsync, Vsync, blankVGA, R, G, B,
`ifdef VGA_RX_PIXCOUNT_EN
        input  hitCount,
`endif
        input  locked, found, frameDone, CircleRow, CircleCol
    );

    // Analyzer side
    modport slave (
        input  Hsync, Vsync, blankVGA, R, G, B,
`ifdef VGA_RX_PIXCOUNT_EN
        output hitCount,
`endif
        output locked, found, frameDone, CircleRow, CircleCol
    );

endinterface

// File: rtl/vga_pos_counter.sv
// Input registers, sync/blank edge detection, row/column position and per-frame
// timing measurements. Emits a one-cycle frame_end with the conformance verdict.
module vga_pos_counter
    import vga_rx_pkg::*;
#(
    parameter int unsigned H_ACT = H_ACTIVE,
    parameter int unsigned V_ACT = V_ACTIVE,
    parameter int unsigned V_TOT = V_TOTAL
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       pix_valid_o,
    output row_t       pix_row_o,
    output col_t       pix_col_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       frame_end_o,
    output logic       conform_o
);

    logic       hs1_q, hs2_q, vs1_q, vs2_q, bl1_q, bl2_q;
    logic [7:0] r_q, g_q, b_q;
    col_t       col_q, col_d, pix_col;
    row_t       row_q, row_d, row_next;
    col_t       lines_q, lines_d, lines_next;
    logic       line_act_q, line_act_d;
    logic       seen_vs_q, seen_vs_d;
    logic       frame_end_q, frame_end_d;
    logic       conform_q, conform_d;
    logic       vs_fall, hs_fall, bl_rise;

    // Position counters and frame measurements
    always_comb begin
        vs_fall = vs2_q & ~vs1_q;
        hs_fall = hs2_q & ~hs1_q;
        bl_rise = bl1_q & ~bl2_q;

        // First active pixel of a line is column 0 even before the clear lands
        pix_col = bl_rise ? '0 : col_q;
        col_d   = col_q;
        if (bl1_q) begin
            col_d = (pix_col == '1) ? pix_col : pix_col + col_t'(1);
        end

        row_next = row_q;
        if (hs_fall && line_act_q && row_q != '1) begin
            row_next = row_q + row_t'(1);
        end
        lines_next = lines_q;
        if (hs_fall && lines_q != '1) begin
            lines_next = lines_q + col_t'(1);
        end

        line_act_d = hs_fall ? bl1_q : (line_act_q | bl1_q);
        // Increments from a coincident Hsync edge land in the measurement before the clear
        row_d       = vs_fall ? '0 : row_next;
        lines_d     = vs_fall ? '0 : lines_next;
        seen_vs_d   = seen_vs_q | vs_fall;
        frame_end_d = vs_fall;
        conform_d   = conform_q;
        if (vs_fall) begin
            // Without a previous Vsync edge the line total is partial
            conform_d = seen_vs_q && (col_q == col_t'(H_ACT)) &&
                        (row_next == row_t'(V_ACT)) && (lines_next == col_t'(V_TOT));
        end
    end

    // Input stages and counter state
    always_ff @(posedge clk25) begin
        if (reset) begin
            hs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vs2_q       <= 1'b1;
            bl1_q       <= 1'b0;
            bl2_q       <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lines_q     <= '0;
            line_act_q  <= 1'b0;
            seen_vs_q   <= 1'b0;
            frame_end_q <= 1'b0;
            conform_q   <= 1'b0;
        end else begin
            hs1_q       <= hsync_i;
            hs2_q       <= hs1_q;
            vs1_q       <= vsync_i;
            vs2_q       <= vs1_q;
            bl1_q       <= blank_i;
            bl2_q       <= bl1_q;
            r_q         <= r_i;
            g_q         <= g_i;
            b_q         <= b_i;
            col_q       <= col_d;
            row_q       <= row_d;
            lines_q     <= lines_d;
            line_act_q  <= line_act_d;
            seen_vs_q   <= seen_vs_d;
            frame_end_q <= frame_end_d;
            conform_q   <= conform_d;
        end
    end

    assign pix_valid_o = bl1_q;
    assign pix_row_o   = row_q;
    assign pix_col_o   = pix_col;
    assign r_o         = r_q;
    assign g_o         = g_q;
    assign b_o         = b_q;
    assign frame_end_o = frame_end_q;
    assign conform_o   = conform_q;

endmodule

// File: rtl/vga_frame_analyzer.sv
// VGA receive-side analyzer: timing lock FSM and target-colour bounding box.
// Optional VGA_RX_PIXCOUNT_EN adds a per-frame hit pixel count on hitCount.
module vga_frame_analyzer
    import vga_rx_pkg::*;
#(
    parameter int unsigned HIT_LEVEL   = 128,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_ACT       = H_ACTIVE,
    parameter int unsigned V_ACT       = V_ACTIVE,
    parameter int unsigned V_TOT       = V_TOTAL
) (
    input logic                clk25,
    input logic                reset,
    vga_frame_analyzer_if.slave bus
);

    localparam logic [8:0] HitLvl  = 9'(HIT_LEVEL);
    localparam logic [7:0] LockTgt = 8'(LOCK_FRAMES);

    logic       pix_valid, frame_end, conform;
    row_t       pix_row;
    col_t       pix_col;
    logic [7:0] pr, pg, pb;

    vga_pos_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .V_TOT (V_TOT)
    ) u_pos (
        .clk25       (clk25),
        .reset       (reset),
        .hsync_i     (bus.Hsync),
        .vsync_i     (bus.Vsync),
        .blank_i     (bus.blankVGA),
        .r_i         (bus.R),
        .g_i         (bus.G),
        .b_i         (bus.B),
        .pix_valid_o (pix_valid),
        .pix_row_o   (pix_row),
        .pix_col_o   (pix_col),
        .r_o         (pr),
        .g_o         (pg),
        .b_o         (pb),
        .frame_end_o (frame_end),
        .conform_o   (conform)
    );

    rx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       locked_q, locked_d, found_q, found_d, frame_done_q, frame_done_d;
    row_t       circle_row_q, circle_row_d, min_row_q, min_row_d, max_row_q, max_row_d;
    col_t       circle_col_q, circle_col_d, min_col_q, min_col_d, max_col_q, max_col_d;
    logic       any_hit_q, any_hit_d, hit;
    logic [9:0] sum_row;
    logic [10:0] sum_col;
`ifdef VGA_RX_PIXCOUNT_EN
    localparam logic [18:0] PixMax = 19'(H_ACT * V_ACT);
    logic [18:0] hit_cnt_q, hit_cnt_d, hit_count_q, hit_count_d;
`endif

    // Hit detection, bounding box, lock FSM and frame results
    always_comb begin
        hit = pix_valid && ({1'b0, pr} >= HitLvl) && ({1'b0, pg} < HitLvl) &&
              ({1'b0, pb} < HitLvl) && (pix_col < col_t'(H_ACT)) && (pix_row < row_t'(V_ACT));
        sum_row = {1'b0, min_row_q} + {1'b0, max_row_q};
        sum_col = {1'b0, min_col_q} + {1'b0, max_col_q};

        state_d      = state_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        frame_done_d = 1'b0;
        circle_row_d = circle_row_q;
        circle_col_d = circle_col_q;
        min_row_d    = min_row_q;
        max_row_d    = max_row_q;
        min_col_d    = min_col_q;
        max_col_d    = max_col_q;
        any_hit_d    = any_hit_q;
`ifdef VGA_RX_PIXCOUNT_EN
        hit_cnt_d    = hit_cnt_q;
        hit_count_d  = hit_count_q;
        if (hit && hit_cnt_q != PixMax) begin
            hit_cnt_d = hit_cnt_q + 19'd1;
        end
`endif

        if (hit) begin
            any_hit_d = 1'b1;
            if (pix_row < min_row_q) min_row_d = pix_row;
            if (pix_row > max_row_q) max_row_d = pix_row;
            if (pix_col < min_col_q) min_col_d = pix_col;
            if (pix_col > max_col_q) max_col_d = pix_col;
        end

        if (frame_end) begin
            frame_done_d = 1'b1;
            found_d      = 1'b0;
            // Results only count from a frame judged while already locked
            if (state_q == LOCKED && conform && any_hit_q) begin
                found_d      = 1'b1;
                circle_row_d = row_t'(sum_row >> 1);
                circle_col_d = col_t'(sum_col >> 1);
            end
            unique case (state_q)
                SEARCH: begin
                    cnt_d   = conform ? 8'd1 : 8'd0;
                    state_d = (conform && 8'd1 >= LockTgt) ? LOCKED : LOCKING;
                end
                LOCKING: begin
                    if (conform) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 >= LockTgt) state_d = LOCKED;
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (!conform) begin
                        state_d = SEARCH;
                        cnt_d   = 8'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
            // Box restarts empty once this frame's result has been taken
            min_row_d = '1;
            max_row_d = '0;
            min_col_d = '1;
            max_col_d = '0;
            any_hit_d = 1'b0;
`ifdef VGA_RX_PIXCOUNT_EN
            hit_count_d = hit_cnt_q;
            hit_cnt_d   = '0;
`endif
        end
        locked_d = (state_d == LOCKED);
    end

    // Lock FSM state, bounding box and registered outputs
    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q      <= SEARCH;
            cnt_q        <= '0;
            locked_q     <= 1'b0;
            found_q      <= 1'b0;
            frame_done_q <= 1'b0;
            circle_row_q <= '0;
            circle_col_q <= '0;
            min_row_q    <= '1;
            max_row_q    <= '0;
            min_col_q    <= '1;
            max_col_q    <= '0;
            any_hit_q    <= 1'b0;
`ifdef VGA_RX_PIXCOUNT_EN
            hit_cnt_q    <= '0;
            hit_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            locked_q     <= locked_d;
            found_q      <= found_d;
            frame_done_q <= frame_done_d;
            circle_row_q <= circle_row_d;
            circle_col_q <= circle_col_d;
            min_row_q    <= min_row_d;
            max_row_q    <= max_row_d;
            min_col_q    <= min_col_d;
            max_col_q    <= max_col_d;
            any_hit_q    <= any_hit_d;
`ifdef VGA_RX_PIXCOUNT_EN
            hit_cnt_q    <= hit_cnt_d;
            hit_count_q  <= hit_count_d;
`endif
        end
    end

    assign bus.locked    = locked_q;
    assign bus.found     = found_q;
    assign bus.frameDone = frame_done_q;
    assign bus.CircleRow = circle_row_q;
    assign bus.CircleCol = circle_col_q;
`ifdef VGA_RX_PIXCOUNT_EN
    assign bus.hitCount  = hit_count_q;
`endif

endmodule

// File: tb/tb_vga_frame_analyzer.sv
// Directed bench for vga_frame_analyzer on a reduced 32x24 active / 27-line geometry
// (40 clocks per line) so that many whole frames fit in a short run.
module tb_vga_frame_analyzer;

    localparam int HA = 32;
    localparam int VA = 24;
    localparam int VT = 27;
    localparam int LINE = 40;

    logic clk25 = 1'b0;
    logic reset = 1'b1;
    always #20 clk25 = ~clk25;

    vga_frame_analyzer_if bus ();

    vga_frame_analyzer #(
        .HIT_LEVEL   (128),
        .LOCK_FRAMES (2),
        .H_ACT       (HA),
        .V_ACT       (VA),
        .V_TOT       (VT)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vs_cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int dbl_cnt  = 0;
    logic fd_prev = 1'b0;
    logic snap_locked, snap_found;
    logic [8:0] snap_row;
    logic [9:0] snap_col;
`ifdef VGA_RX_PIXCOUNT_EN
    logic [18:0] snap_hits;
`endif

    // Target box and background selection
    logic box_on = 1'b0;
    logic bg_on  = 1'b0;
    int br0, br1, bc0, bc1;

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (bus.frameDone) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            snap_locked <= bus.locked;
            snap_found  <= bus.found;
            snap_row    <= bus.CircleRow;
            snap_col    <= bus.CircleCol;
`ifdef VGA_RX_PIXCOUNT_EN
            snap_hits   <= bus.hitCount;
`endif
            if (fd_prev) dbl_cnt <= dbl_cnt + 1;
        end
        fd_prev <= bus.frameDone;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic send_line(input int v, input int nlines);
        logic act;
        for (int h = 0; h < LINE; h++) begin
            @(negedge clk25);
            if (v == nlines - 2 && h == 0) vs_cyc = cyc;
            bus.Vsync    = !(v >= nlines - 2);
            bus.Hsync    = !(h >= 34 && h < 38);
            act          = (v < VA) && (h < HA);
            bus.blankVGA = act;
            if (act && box_on && v >= br0 && v <= br1 && h >= bc0 && h <= bc1) begin
                // Exactly at threshold on R, one below on G/B: a hit
                bus.R = 8'd128; bus.G = 8'd127; bus.B = 8'd127;
            end else if (act && bg_on) begin
                // Red with G or B at threshold: never a hit
                bus.R = 8'd255;
                bus.G = (h % 2 == 0) ? 8'd128 : 8'd0;
                bus.B = (h % 2 == 0) ? 8'd0 : 8'd128;
            end else begin
                bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
            end
        end
    endtask

    task automatic send_frame(input int nlines);
        for (int v = 0; v < nlines; v++) send_line(v, nlines);
    endtask

    initial begin
        int base;
        bus.Hsync = 1'b1; bus.Vsync = 1'b1; bus.blankVGA = 1'b0;
        bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
        br0 = 0; br1 = 0; bc0 = 0; bc1 = 0;
        repeat (3) @(negedge clk25);
        reset = 1'b0;
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_found", 32'(bus.found), 0);
        check("rst_frameDone", 32'(bus.frameDone), 0);
        check("rst_row", 32'(bus.CircleRow), 0);
        check("rst_col", 32'(bus.CircleCol), 0);

        // Three black frames: lock on the third frameDone
        send_frame(VT);
        check("f1_locked", 32'(snap_locked), 0);
        send_frame(VT);
        check("f2_locked", 32'(snap_locked), 0);
        send_frame(VT);
        check("f3_locked", 32'(snap_locked), 1);
        check("f3_found", 32'(snap_found), 0);
        check("f3_row", 32'(snap_row), 0);
        check("f3_col", 32'(snap_col), 0);
        check("done_count", 32'(done_cnt), 3);
        check("done_latency", 32'(done_cyc - vs_cyc), 3);
        check("done_one_cycle", 32'(dbl_cnt), 0);

        // 10x10 square rows 5..14, cols 8..17 on a near-miss background
        bg_on = 1'b1; box_on = 1'b1;
        br0 = 5; br1 = 14; bc0 = 8; bc1 = 17;
        send_frame(VT);
        check("sq_locked", 32'(snap_locked), 1);
        check("sq_found", 32'(snap_found), 1);
        check("sq_row", 32'(snap_row), 9);
        check("sq_col", 32'(snap_col), 12);
`ifdef VGA_RX_PIXCOUNT_EN
        check("sq_hitCount", 32'(snap_hits), 100);
`endif

        // Single hit at the last active pixel
        br0 = VA - 1; br1 = VA - 1; bc0 = HA - 1; bc1 = HA - 1;
        send_frame(VT);
        check("corner_found", 32'(snap_found), 1);
        check("corner_row", 32'(snap_row), VA - 1);
        check("corner_col", 32'(snap_col), HA - 1);

        // No hits while locked: found drops, coordinates hold
        box_on = 1'b0;
        send_frame(VT);
        check("nohit_locked", 32'(snap_locked), 1);
        check("nohit_found", 32'(snap_found), 0);
        check("nohit_row", 32'(snap_row), VA - 1);
        check("nohit_col", 32'(snap_col), HA - 1);

        // One short frame drops lock
        box_on = 1'b1; br0 = 5; br1 = 14; bc0 = 8; bc1 = 17;
        send_frame(VT - 1);
        check("short_locked", 32'(snap_locked), 0);
        check("short_found", 32'(snap_found), 0);
        check("short_row", 32'(snap_row), VA - 1);
        check("short_col", 32'(snap_col), HA - 1);
        send_frame(VT);
        check("relock1_locked", 32'(snap_locked), 0);
        check("relock1_found", 32'(snap_found), 0);
        check("relock1_row", 32'(snap_row), VA - 1);
        send_frame(VT);
        check("relock2_locked", 32'(snap_locked), 1);
        check("relock2_found", 32'(snap_found), 0);
        send_frame(VT);
        check("relock3_found", 32'(snap_found), 1);
        check("relock3_row", 32'(snap_row), 9);
        check("relock3_col", 32'(snap_col), 12);

        // Reset mid-frame at row 12
        for (int v = 0; v < 12; v++) send_line(v, VT);
        @(negedge clk25);
        bus.blankVGA = 1'b0; bus.Hsync = 1'b1; bus.Vsync = 1'b1;
        reset = 1'b1;
        @(negedge clk25);
        reset = 1'b0;
        check("mid_rst_locked", 32'(bus.locked), 0);
        check("mid_rst_found", 32'(bus.found), 0);
        check("mid_rst_frameDone", 32'(bus.frameDone), 0);
        check("mid_rst_row", 32'(bus.CircleRow), 0);
        check("mid_rst_col", 32'(bus.CircleCol), 0);
        base = done_cnt;
        for (int v = 12; v < VT; v++) send_line(v, VT);
        check("edge1_locked", 32'(snap_locked), 0);
        send_frame(VT);
        check("edge2_locked", 32'(snap_locked), 0);
        send_frame(VT);
        check("edge3_locked", 32'(snap_locked), 1);
        check("edge3_done_count", 32'(done_cnt - base), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
